// File: rtl/mio_pkg.sv
// mio_pkg: DMA master state encoding and memory/IO bus region base addresses
package mio_pkg;

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_RD, S_WR, S_NEXT, S_FIN} dma_state_e;

    localparam logic [31:0] VRAM_BASE = 32'hc000_0000;
    localparam logic [31:0] RAM_BASE  = 32'h0000_0800;
    localparam logic [31:0] SEG_BASE  = 32'h0000_7f10;

endpackage

// File: rtl/mio_dma_addr_gen.sv
// mio_dma_addr_gen: source/destination address and remaining-word counters for the DMA master
//   clk, clrn       clock, asynchronous active-low reset
//   load_i          capture src_i/dst_i/len_i/step_i at command start
//   adv_i           advance both addresses by step and count one word done
//   src_o, dst_o    current source/destination address
//   last_o          the word just transferred was the final one
module mio_dma_addr_gen
    import mio_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             load_i,
    input  logic             adv_i,
    input  logic [31:0]      src_i,
    input  logic [31:0]      dst_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic [3:0]       step_i,
    output logic [31:0]      src_o,
    output logic [31:0]      dst_o,
    output logic             last_o
);

    logic [31:0]      src_q, src_d, dst_q, dst_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [3:0]       step_q, step_d;

    // Address arithmetic wraps modulo 2^32 by design.
    always_comb begin
        src_d  = load_i ? src_i  : adv_i ? src_q + {28'd0, step_q} : src_q;
        dst_d  = load_i ? dst_i  : adv_i ? dst_q + {28'd0, step_q} : dst_q;
        rem_d  = load_i ? len_i  : adv_i ? rem_q - 1'b1 : rem_q;
        step_d = load_i ? step_i : step_q;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            src_q  <= '0;
            dst_q  <= '0;
            rem_q  <= '0;
            step_q <= '0;
        end else begin
            src_q  <= src_d;
            dst_q  <= dst_d;
            rem_q  <= rem_d;
            step_q <= step_d;
        end
    end

    assign src_o  = src_q;
    assign dst_o  = dst_q;
    assign last_o = rem_q == LEN_W'(1);

endmodule

// File: rtl/mio_dma_master.sv
// mio_dma_master: memory/IO bus initiator performing block COPY and FILL beside the CPU
//   Optional build macro MIO_DMA_IRQ_EN adds a sticky completion interrupt (irq/irq_ack).
//   clk, clrn                 clock, asynchronous active-low reset
//   cmd_start .. cmd_abort    command interface, start accepted only while idle
//   busy, done                command in progress, one-cycle completion/abort pulse
//   bus_req, bus_gnt          arbiter handshake
//   mem_a, d_t_mem, d_f_mem   bus address, write data, read data
//   wmem, rmem                write/read strobes, only while granted
module mio_dma_master
    import mio_pkg::*;
#(
    parameter int LEN_W   = 16,
    parameter int RD_WAIT = 1
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             cmd_start,
    input  logic             cmd_fill_md,
    input  logic [31:0]      cmd_src,
    input  logic [31:0]      cmd_dst,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic [3:0]       cmd_step,
    input  logic [31:0]      cmd_fill,
    input  logic             cmd_abort,
    output logic             busy,
    output logic             done,
    output logic             bus_req,
    input  logic             bus_gnt,
    output logic [31:0]      mem_a,
    output logic [31:0]      d_t_mem,
`ifdef MIO_DMA_IRQ_EN
    output logic             irq,
    input  logic             irq_ack,
`endif
    input  logic [31:0]      d_f_mem,
    output logic             wmem,
    output logic             rmem
);

    localparam int CW = $clog2(RD_WAIT + 1);

    dma_state_e    state_q, state_d;
    logic          fill_md_q, fill_md_d, abort_q, abort_d;
    logic [31:0]   data_q, data_d;
    logic [CW-1:0] rd_cnt_q, rd_cnt_d;
    logic [31:0]   src, dst;
    logic          last, abort_pend, rd_last;

    mio_dma_addr_gen #(.LEN_W(LEN_W)) u_addr (
        .clk    (clk),
        .clrn   (clrn),
        .load_i (state_q == S_IDLE && cmd_start),
        .adv_i  (state_q == S_NEXT),
        .src_i  (cmd_src),
        .dst_i  (cmd_dst),
        .len_i  (cmd_len),
        .step_i (cmd_step),
        .src_o  (src),
        .dst_o  (dst),
        .last_o (last)
    );

    assign abort_pend = abort_q | cmd_abort;
    assign rd_last    = rd_cnt_q == CW'(RD_WAIT - 1);

    // FILL preloads the data register with the constant so WR drives it in both modes.
    always_comb begin
        state_d   = state_q;
        fill_md_d = fill_md_q;
        data_d    = data_q;
        rd_cnt_d  = rd_cnt_q;
        abort_d   = state_q != S_IDLE && state_q != S_FIN && abort_pend;
        case (state_q)
            S_IDLE: if (cmd_start) begin
                fill_md_d = cmd_fill_md;
                data_d    = cmd_fill;
                state_d   = (cmd_len == '0 || cmd_abort) ? S_FIN : S_REQ;
            end
            S_REQ:  state_d = abort_pend ? S_FIN : !bus_gnt ? S_REQ : fill_md_q ? S_WR : S_RD;
            S_RD: begin
                rd_cnt_d = (!bus_gnt || rd_last) ? '0 : rd_cnt_q + 1'b1;
                data_d   = (bus_gnt && rd_last) ? d_f_mem : data_q;
                state_d  = !bus_gnt ? S_REQ : rd_last ? S_WR : S_RD;
            end
            S_WR:   state_d = S_NEXT;
            S_NEXT: state_d = (last || abort_pend) ? S_FIN : !bus_gnt ? S_REQ : fill_md_q ? S_WR : S_RD;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q   <= S_IDLE;
            fill_md_q <= 1'b0;
            abort_q   <= 1'b0;
            data_q    <= '0;
            rd_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            fill_md_q <= fill_md_d;
            abort_q   <= abort_d;
            data_q    <= data_d;
            rd_cnt_q  <= rd_cnt_d;
        end
    end

    // Strobes are decoded straight from state so an async reset drops them at once.
    assign busy    = state_q != S_IDLE;
    assign done    = state_q == S_FIN;
    assign bus_req = state_q inside {S_REQ, S_RD, S_WR, S_NEXT};
    assign rmem    = state_q == S_RD && bus_gnt;
    assign wmem    = state_q == S_WR && bus_gnt;
    assign mem_a   = state_q == S_RD ? src : state_q == S_WR ? dst : '0;
    assign d_t_mem = state_q == S_WR ? data_q : '0;

`ifdef MIO_DMA_IRQ_EN
    logic irq_q, irq_d;
    assign irq_d = state_q == S_FIN || (irq_q && !irq_ack);
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) irq_q <= 1'b0;
        else       irq_q <= irq_d;
    end
    assign irq = irq_q;
`endif

endmodule
